mem_port_arbiter: RTL and testbench

//   Shares the single external memory port between the instruction-fetch port (if_*, driven by
//   the fetch stage) and the data port (dm_*, driven by the memory stage).

---
 rtl/mem_port_arbiter.sv | 140 ++++++++++++++
 tb/tb_mem_port_arbiter.sv | 396 +++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_port_arbiter.sv
// Arbitrates the single external memory port between instruction fetch and data access,
// with a watchdog abort. Define ARB_ROUND_ROBIN_EN for round-robin ties (default: DM wins ties).
module mem_port_arbiter #(
  parameter int WORD_WIDTH     = 32,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [WORD_WIDTH-1:0]   if_addr,
  input  logic                    if_read,
  output logic [WORD_WIDTH-1:0]   if_rdata,
  output logic                    if_resp,
  output logic                    if_stall,
  input  logic [WORD_WIDTH-1:0]   dm_addr,
  input  logic                    dm_read,
  input  logic                    dm_write,
  input  logic [WORD_WIDTH-1:0]   dm_wdata,
  input  logic [WORD_WIDTH/8-1:0] dm_wmask,
  output logic [WORD_WIDTH-1:0]   dm_rdata,
  output logic                    dm_resp,
  output logic                    dm_stall,
  output logic [WORD_WIDTH-1:0]   mem_addr,
  output logic                    mem_read,
  output logic                    mem_write,
  output logic [WORD_WIDTH-1:0]   mem_wdata,
  output logic [WORD_WIDTH/8-1:0] mem_wmask,
  input  logic [WORD_WIDTH-1:0]   mem_rdata,
  input  logic                    mem_resp,
  output logic                    bus_err
);

  localparam int WD_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [WD_W-1:0] WD_LIMIT = WD_W'(TIMEOUT_CYCLES);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    GNT_IF = 2'd1,
    GNT_DM = 2'd2
  } state_t;

  state_t                  state;
  logic [WD_W-1:0]         wdog;
  logic [WORD_WIDTH-1:0]   if_rdata_q;
  logic [WORD_WIDTH-1:0]   dm_rdata_q;
  logic [WORD_WIDTH-1:0]   resp_data;
  logic                    if_req;
  logic                    dm_req;
  logic                    pick_dm;
  logic                    timeout;
  logic                    done;

  assign if_req = if_read;
  assign dm_req = dm_read | dm_write;

`ifdef ARB_ROUND_ROBIN_EN
  logic last_gnt_dm;
  assign pick_dm = dm_req & (~if_req | ~last_gnt_dm);
`else
  assign pick_dm = dm_req;
`endif

  assign timeout = (wdog == WD_LIMIT);
  assign done    = (state != IDLE) & (mem_resp | timeout);
  assign if_resp = (state == GNT_IF) & (mem_resp | timeout);
  assign dm_resp = (state == GNT_DM) & (mem_resp | timeout);

  // A real response beats a simultaneous timeout; an abort returns zero.
  assign resp_data = mem_resp ? mem_rdata : '0;
  assign if_rdata  = if_resp ? resp_data : if_rdata_q;
  assign dm_rdata  = dm_resp ? resp_data : dm_rdata_q;

  assign if_stall = if_read & ~if_resp;
  assign dm_stall = dm_req & ~dm_resp;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= IDLE;
      wdog       <= '0;
      bus_err    <= 1'b0;
      mem_addr   <= '0;
      mem_read   <= 1'b0;
      mem_write  <= 1'b0;
      mem_wdata  <= '0;
      mem_wmask  <= '0;
      if_rdata_q <= '0;
      dm_rdata_q <= '0;
`ifdef ARB_ROUND_ROBIN_EN
      last_gnt_dm <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          wdog <= '0;
          if (pick_dm) begin
            state     <= GNT_DM;
            mem_addr  <= dm_addr;
            mem_read  <= dm_read;
            mem_write <= dm_write & ~dm_read;
            mem_wdata <= dm_wdata;
            mem_wmask <= (dm_write & ~dm_read) ? dm_wmask : '1;
`ifdef ARB_ROUND_ROBIN_EN
            last_gnt_dm <= 1'b1;
`endif
          end else if (if_req) begin
            state     <= GNT_IF;
            mem_addr  <= if_addr;
            mem_read  <= 1'b1;
            mem_write <= 1'b0;
            mem_wdata <= '0;
            mem_wmask <= '1;
`ifdef ARB_ROUND_ROBIN_EN
            last_gnt_dm <= 1'b0;
`endif
          end
        end
        GNT_IF, GNT_DM: begin
          if (done) begin
            state     <= IDLE;
            wdog      <= '0;
            mem_read  <= 1'b0;
            mem_write <= 1'b0;
            if (!mem_resp) bus_err <= 1'b1;
            if (state == GNT_IF) if_rdata_q <= resp_data;
            else                 dm_rdata_q <= resp_data;
          end else begin
            // Never wraps: the transaction ends when the count hits the limit.
            wdog <= wdog + WD_W'(1);
          end
        end
        default: begin
          state     <= IDLE;
          wdog      <= '0;
          mem_read  <= 1'b0;
          mem_write <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: directed scenarios plus randomized traffic against a
// transaction-level reference model.
module tb_mem_port_arbiter;
  localparam int W  = 32;
  localparam int TO = 4;

  logic         clk = 1'b0;
  logic         rst_n;
  logic [W-1:0] if_addr, if_rdata;
  logic         if_read, if_resp, if_stall;
  logic [W-1:0] dm_addr, dm_wdata, dm_rdata;
  logic         dm_read, dm_write, dm_resp, dm_stall;
  logic [W/8-1:0] dm_wmask, mem_wmask;
  logic [W-1:0] mem_addr, mem_wdata, mem_rdata;
  logic         mem_read, mem_write, mem_resp, bus_err;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  mem_port_arbiter #(.WORD_WIDTH(W), .TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .rst_n(rst_n),
    .if_addr(if_addr), .if_read(if_read), .if_rdata(if_rdata), .if_resp(if_resp),
    .if_stall(if_stall),
    .dm_addr(dm_addr), .dm_read(dm_read), .dm_write(dm_write), .dm_wdata(dm_wdata),
    .dm_wmask(dm_wmask), .dm_rdata(dm_rdata), .dm_resp(dm_resp), .dm_stall(dm_stall),
    .mem_addr(mem_addr), .mem_read(mem_read), .mem_write(mem_write), .mem_wdata(mem_wdata),
    .mem_wmask(mem_wmask), .mem_rdata(mem_rdata), .mem_resp(mem_resp), .bus_err(bus_err)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    if_addr = '0; if_read = 1'b0;
    dm_addr = '0; dm_read = 1'b0; dm_write = 1'b0; dm_wdata = '0; dm_wmask = '0;
    mem_rdata = '0; mem_resp = 1'b0;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    idle_inputs();
    tick();
    tick();
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    idle_inputs();
    mem_resp = 1'b1;
    mem_rdata = 32'hCAFE_F00D;
    tick();
    tick();
    mem_resp = 1'b0;
    @(negedge clk);
    n_cmp++;
    if ({mem_read, mem_write, if_resp, dm_resp, bus_err, if_stall, dm_stall} !== 7'b0) begin
      n_err++;
      $display("FAIL reset_ctrl got %b want 0000000",
               {mem_read, mem_write, if_resp, dm_resp, bus_err, if_stall, dm_stall});
    end
    n_cmp++;
    if ({mem_addr, mem_wdata, mem_wmask, if_rdata, dm_rdata} !== '0) begin
      n_err++;
      $display("FAIL reset_data got addr=%h wdata=%h wmask=%h if_rdata=%h dm_rdata=%h want all 0",
               mem_addr, mem_wdata, mem_wmask, if_rdata, dm_rdata);
    end
    tick();
    rst_n = 1'b1;
  endtask

  task automatic test_fetch();
    if_read = 1'b1;
    if_addr = 32'h100;
    @(negedge clk);
    n_cmp++;
    if (mem_read !== 1'b0 || if_stall !== 1'b1) begin
      n_err++;
      $display("FAIL fetch_idle got mem_read=%b if_stall=%b want 0 1", mem_read, if_stall);
    end
    tick();
    @(negedge clk);
    n_cmp++;
    if (mem_read !== 1'b1 || mem_write !== 1'b0 || mem_addr !== 32'h100 ||
        mem_wmask !== 4'hF || if_resp !== 1'b0) begin
      n_err++;
      $display("FAIL fetch_grant got rd=%b wr=%b addr=%h mask=%h resp=%b want 1 0 100 f 0",
               mem_read, mem_write, mem_addr, mem_wmask, if_resp);
    end
    tick();
    tick();
    mem_resp = 1'b1;
    mem_rdata = 32'h0000_0013;
    @(negedge clk);
    n_cmp++;
    if (if_resp !== 1'b1 || if_rdata !== 32'h13 || if_stall !== 1'b0) begin
      n_err++;
      $display("FAIL fetch_resp got resp=%b rdata=%h stall=%b want 1 00000013 0",
               if_resp, if_rdata, if_stall);
    end
    tick();
    mem_resp = 1'b0;
    mem_rdata = 32'hBAD0_BAD0;
    if_read = 1'b0;
    @(negedge clk);
    n_cmp++;
    if (mem_read !== 1'b0 || if_resp !== 1'b0 || if_rdata !== 32'h13) begin
      n_err++;
      $display("FAIL fetch_after got rd=%b resp=%b rdata=%h want 0 0 00000013",
               mem_read, if_resp, if_rdata);
    end
    tick();
  endtask

  task automatic test_dm_write();
    dm_write = 1'b1;
    dm_addr  = 32'h2000;
    dm_wdata = 32'hDEAD_BEEF;
    dm_wmask = 4'b0011;
    tick();
    @(negedge clk);
    n_cmp++;
    if (mem_write !== 1'b1 || mem_read !== 1'b0 || mem_addr !== 32'h2000 ||
        mem_wdata !== 32'hDEAD_BEEF || mem_wmask !== 4'b0011 || dm_stall !== 1'b1) begin
      n_err++;
      $display("FAIL dmw_grant got wr=%b rd=%b addr=%h wdata=%h mask=%b stall=%b want 1 0 2000 deadbeef 0011 1",
               mem_write, mem_read, mem_addr, mem_wdata, mem_wmask, dm_stall);
    end
    tick();
    mem_resp = 1'b1;
    @(negedge clk);
    n_cmp++;
    if (dm_resp !== 1'b1 || dm_stall !== 1'b0 || if_resp !== 1'b0) begin
      n_err++;
      $display("FAIL dmw_resp got dm_resp=%b dm_stall=%b if_resp=%b want 1 0 0",
               dm_resp, dm_stall, if_resp);
    end
    tick();
    mem_resp = 1'b0;
    dm_write = 1'b0;
    @(negedge clk);
    n_cmp++;
    if (mem_write !== 1'b0 || dm_resp !== 1'b0) begin
      n_err++;
      $display("FAIL dmw_after got wr=%b resp=%b want 0 0", mem_write, dm_resp);
    end
    tick();
  endtask

  task automatic test_tie();
    logic exp_dm;
    do_reset();
    if_read = 1'b1; if_addr = 32'hA0;
    dm_read = 1'b1; dm_addr = 32'hD0;
    for (int g = 0; g < 4; g++) begin
`ifdef ARB_ROUND_ROBIN_EN
      exp_dm = (g % 2 == 0);
`else
      exp_dm = 1'b1;
`endif
      tick();
      mem_resp = 1'b1;
      mem_rdata = 32'h700 + g;
      @(negedge clk);
      n_cmp++;
      if (mem_addr !== (exp_dm ? 32'hD0 : 32'hA0) || dm_resp !== exp_dm || if_resp !== !exp_dm) begin
        n_err++;
        $display("FAIL tie_grant%0d got addr=%h dm_resp=%b if_resp=%b want dm=%b", g,
                 mem_addr, dm_resp, if_resp, exp_dm);
      end
      tick();
      mem_resp = 1'b0;
    end
    dm_read = 1'b0;
    tick();
    mem_resp = 1'b1;
    mem_rdata = 32'h1234;
    @(negedge clk);
    n_cmp++;
    if (mem_addr !== 32'hA0 || if_resp !== 1'b1 || if_rdata !== 32'h1234) begin
      n_err++;
      $display("FAIL tie_if_after_dm got addr=%h resp=%b rdata=%h want a0 1 00001234",
               mem_addr, if_resp, if_rdata);
    end
    tick();
    mem_resp = 1'b0;
    if_read = 1'b0;
    tick();
  endtask

  task automatic test_timeout();
    do_reset();
    if_read = 1'b1;
    if_addr = 32'h44;
    mem_rdata = 32'hFFFF_FFFF;
    tick();
    for (int k = 1; k <= TO; k++) begin
      @(negedge clk);
      n_cmp++;
      if (if_resp !== 1'b0 || mem_read !== 1'b1) begin
        n_err++;
        $display("FAIL timeout_wait%0d got resp=%b rd=%b want 0 1", k, if_resp, mem_read);
      end
      tick();
    end
    @(negedge clk);
    n_cmp++;
    if (if_resp !== 1'b1 || if_rdata !== 32'h0 || bus_err !== 1'b0) begin
      n_err++;
      $display("FAIL timeout_abort got resp=%b rdata=%h bus_err=%b want 1 0 0",
               if_resp, if_rdata, bus_err);
    end
    tick();
    if_read = 1'b0;
    @(negedge clk);
    n_cmp++;
    if (bus_err !== 1'b1 || mem_read !== 1'b0 || if_resp !== 1'b0) begin
      n_err++;
      $display("FAIL timeout_after got bus_err=%b rd=%b resp=%b want 1 0 0",
               bus_err, mem_read, if_resp);
    end
    repeat (3) tick();
    @(negedge clk);
    n_cmp++;
    if (bus_err !== 1'b1) begin
      n_err++;
      $display("FAIL timeout_sticky got bus_err=%b want 1", bus_err);
    end
    tick();
  endtask

  task automatic test_reset_mid();
    dm_write = 1'b1;
    dm_addr  = 32'h3000;
    dm_wdata = 32'h0BAD_CAFE;
    dm_wmask = 4'hF;
    tick();
    @(negedge clk);
    n_cmp++;
    if (mem_write !== 1'b1 || bus_err !== 1'b1) begin
      n_err++;
      $display("FAIL rstmid_grant got wr=%b bus_err=%b want 1 1", mem_write, bus_err);
    end
    tick();
    rst_n = 1'b0;
    @(negedge clk);
    n_cmp++;
    if (dm_resp !== 1'b0) begin
      n_err++;
      $display("FAIL rstmid_noresp got dm_resp=%b want 0", dm_resp);
    end
    tick();
    @(negedge clk);
    n_cmp++;
    if (mem_write !== 1'b0 || dm_resp !== 1'b0 || bus_err !== 1'b0) begin
      n_err++;
      $display("FAIL rstmid_after got wr=%b resp=%b bus_err=%b want 0 0 0",
               mem_write, dm_resp, bus_err);
    end
    tick();
    rst_n = 1'b1;
    dm_write = 1'b0;
    tick();
  endtask

  task automatic test_resp_at_timeout();
    do_reset();
    if_read = 1'b1;
    if_addr = 32'h48;
    tick();
    repeat (TO) tick();
    mem_resp = 1'b1;
    mem_rdata = 32'h55;
    @(negedge clk);
    n_cmp++;
    if (if_resp !== 1'b1 || if_rdata !== 32'h55) begin
      n_err++;
      $display("FAIL race_resp got resp=%b rdata=%h want 1 00000055", if_resp, if_rdata);
    end
    tick();
    mem_resp = 1'b0;
    if_read = 1'b0;
    @(negedge clk);
    n_cmp++;
    if (bus_err !== 1'b0 || if_rdata !== 32'h55 || mem_read !== 1'b0) begin
      n_err++;
      $display("FAIL race_after got bus_err=%b rdata=%h rd=%b want 0 00000055 0",
               bus_err, if_rdata, mem_read);
    end
    tick();
  endtask

  // Reference model: who owns the port, how long it has held it, and what it asked for.
  task automatic test_random();
    int owner;
    int age, lat;
    bit wr, berr, last_dm, pdm, tmo, if_done, dm_done;
    logic [W-1:0] a, wd, ifq, dmq, rv, e_if_rdata, e_dm_rdata;
    logic [W/8-1:0] wm;
    logic e_if_resp, e_dm_resp;
    logic [W*2+6:0] got, exp;
    do_reset();
    owner = 0; age = 0; lat = 1; wr = 0; berr = 0; last_dm = 0;
    ifq = '0; dmq = '0; a = '0; wd = '0; wm = '0;
    if_done = 0; dm_done = 0;
    for (int c = 0; c < 3000; c++) begin
      if (!if_read || if_done) begin
        if_read = ($urandom_range(0, 2) != 0);
        if_addr = $urandom;
      end
      if (!(dm_read || dm_write) || dm_done) begin
        case ($urandom_range(0, 2))
          0:       {dm_read, dm_write} = 2'b00;
          1:       {dm_read, dm_write} = 2'b10;
          default: {dm_read, dm_write} = 2'b01;
        endcase
        dm_addr = $urandom; dm_wdata = $urandom; dm_wmask = 4'($urandom);
      end
      if (owner != 0) mem_resp = (age == lat);
      else            mem_resp = ($urandom_range(0, 3) == 0);
      mem_rdata = $urandom;
      @(negedge clk);
      tmo = (owner != 0) && (age == TO + 1);
      e_if_resp = (owner == 1) && (mem_resp || tmo);
      e_dm_resp = (owner == 2) && (mem_resp || tmo);
      rv = mem_resp ? mem_rdata : '0;
      e_if_rdata = e_if_resp ? rv : ifq;
      e_dm_rdata = e_dm_resp ? rv : dmq;
      exp = {e_if_resp, e_dm_resp, e_if_rdata, e_dm_rdata,
             (owner != 0) && !wr, (owner != 0) && wr, berr,
             if_read && !e_if_resp, (dm_read || dm_write) && !e_dm_resp};
      got = {if_resp, dm_resp, if_rdata, dm_rdata, mem_read, mem_write, bus_err, if_stall, dm_stall};
      n_cmp++;
      if (got !== exp) begin
        n_err++;
        $display("FAIL rand_ctrl cycle %0d got %h want %h", c, got, exp);
      end
      if (owner != 0) begin
        n_cmp++;
        if (mem_addr !== a || mem_wmask !== (wr ? wm : 4'hF) || (wr && mem_wdata !== wd)) begin
          n_err++;
          $display("FAIL rand_bus cycle %0d got addr=%h mask=%h wdata=%h want %h %h %h",
                   c, mem_addr, mem_wmask, mem_wdata, a, (wr ? wm : 4'hF), wd);
        end
      end
      if_done = e_if_resp;
      dm_done = e_dm_resp;
      @(posedge clk);
      if (owner == 0) begin
`ifdef ARB_ROUND_ROBIN_EN
        pdm = (dm_read || dm_write) && (!if_read || !last_dm);
`else
        pdm = dm_read || dm_write;
`endif
        if (pdm) begin
          owner = 2; wr = dm_write; a = dm_addr; wd = dm_wdata; wm = dm_wmask; last_dm = 1;
        end else if (if_read) begin
          owner = 1; wr = 0; a = if_addr; last_dm = 0;
        end
        age = 1;
        lat = ($urandom_range(0, 7) == 0) ? TO + 3 : $urandom_range(1, TO + 1);
      end else if (e_if_resp || e_dm_resp) begin
        if (e_if_resp) ifq = e_if_rdata;
        else           dmq = e_dm_rdata;
        if (tmo && !mem_resp) berr = 1;
        owner = 0;
      end else begin
        age++;
      end
      #1;
    end
    idle_inputs();
    tick();
  endtask

  initial begin
    rst_n = 1'b0;
    idle_inputs();
    tick();
    test_reset();
    test_fetch();
    test_dm_write();
    test_tie();
    test_timeout();
    test_reset_mid();
    test_resp_at_timeout();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
